// File: rtl/div_pkg.sv
// Shared definitions for the sequential multiplier/divider family:
// default operand width, FSM state type and step-counter sizing.
package div_pkg;

  localparam int WIDTH_DEF = 16;

  // Counter wide enough to count WIDTH steps with headroom for the wrap.
  localparam int CNT_W = $clog2(WIDTH_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for a non-default operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit a quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   prem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   prem_next,
  output logic             q
);

  // One extra bit above the partial remainder so the trial subtraction
  // never loses its carry.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted   = {prem, dbit};
  assign q         = (shifted >= {2'b00, divisor});
  assign trial     = shifted - {2'b00, divisor};
  // Restore (keep the shifted value) when the divisor does not fit.
  assign prem_next = (WIDTH+1)'(q ? trial : shifted);

endmodule

// File: rtl/div_16_16_seq.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first.
// IDLE latches operands on en, BUSY runs WIDTH steps, DONE pulses valid
// for one cycle. Divide-by-zero skips BUSY and reports all-ones / a.
module div_16_16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             valid,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] work_reg;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH:0]   prem_reg;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             busy_reg;
  logic             valid_reg;
  logic             div_zero_reg;

  logic [WIDTH:0]   prem_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem_reg),
    .dbit      (work_reg[WIDTH-1]),
    .divisor   (divisor_reg),
    .prem_next (prem_next),
    .q         (q_bit)
  );

  // FSM, step counter, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      work_reg     <= '0;
      divisor_reg  <= '0;
      prem_reg     <= '0;
      out_reg      <= '0;
      rem_reg      <= '0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en) begin
            work_reg    <= a;
            divisor_reg <= b;
            prem_reg    <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            if (b == '0) begin
              // No steps to run: the result is defined directly.
              out_reg      <= '1;
              rem_reg      <= a;
              div_zero_reg <= 1'b1;
              valid_reg    <= 1'b1;
              state_reg    <= DONE;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          prem_reg <= prem_next;
          work_reg <= {work_reg[WIDTH-2:0], q_bit};
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // Last step: publish its outcome directly, not the stale register.
            cnt_reg      <= '0;
            out_reg      <= {work_reg[WIDTH-2:0], q_bit};
            rem_reg      <= prem_next[WIDTH-1:0];
            div_zero_reg <= 1'b0;
            valid_reg    <= 1'b1;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out      = out_reg;
  assign rem      = rem_reg;
  assign busy     = busy_reg;
  assign valid    = valid_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_16_16_seq.sv
// Self-checking bench for div_16_16_seq: directed cases, back-to-back,
// divide-by-zero, held en, mid-division reset and a random sweep, all
// checked against plain integer division.
module tb_div_16_16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] out;
  logic [15:0] rem;
  logic        busy;
  logic        valid;
  logic        div_zero;

  int err_cnt = 0;
  int chk_cnt = 0;
  int lat;
  int pulses;

  div_16_16_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a        (a),
    .b        (b),
    .out      (out),
    .rem      (rem),
    .busy     (busy),
    .valid    (valid),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start one operation; returns with the bench at the negedge where valid
  // was first seen (or the cycle budget ran out). lat counts rising edges
  // from the sampling edge (inclusive) to the edge that raised valid.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                       input bit sync, output int lt);
    if (sync) @(negedge clk);
    a  = ta;
    b  = tbv;
    en = 1'b1;
    @(posedge clk);
    lt = 1;
    @(negedge clk);
    en = 1'b0;
    while (!valid && lt < 40) begin
      @(posedge clk);
      lt++;
      @(negedge clk);
    end
  endtask

  // Compare against integer division; b==0 has its own defined result.
  task automatic check_result(input logic [15:0] ta, input logic [15:0] tbv, input int lt);
    logic [15:0] exp_q, exp_r;
    logic        exp_dz;
    int          exp_lat;
    logic [31:0] recon;
    if (tbv == 16'd0) begin
      exp_q = 16'hFFFF; exp_r = ta; exp_dz = 1'b1; exp_lat = 1;
    end else begin
      exp_q = ta / tbv; exp_r = ta % tbv; exp_dz = 1'b0; exp_lat = 17;
    end
    check("valid", {31'd0, valid}, 32'd1);
    check("latency", lt, exp_lat);
    check("quot", {16'd0, out}, {16'd0, exp_q});
    check("rem", {16'd0, rem}, {16'd0, exp_r});
    check("div_zero", {31'd0, div_zero}, {31'd0, exp_dz});
    check("busy_done", {31'd0, busy}, 32'd1);
    if (tbv != 16'd0) begin
      recon = {16'd0, out} * {16'd0, tbv} + {16'd0, rem};
      check("identity", recon, {16'd0, ta});
      check("rem_lt_b", {31'd0, (rem < tbv)}, 32'd1);
    end
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", ta, tbv, out, rem, div_zero, lt);
  endtask

  // One cycle later the block must be back in IDLE with valid dropped.
  task automatic check_idle();
    @(negedge clk);
    check("valid_pulse", {31'd0, valid}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  logic [15:0] edge_a [7] = '{16'd0, 16'd0, 16'd12345, 16'd3, 16'd65535, 16'd1, 16'd65535};
  logic [15:0] edge_b [7] = '{16'd7, 16'd1, 16'd1, 16'd9, 16'd65535, 16'd65535, 16'd2};

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_rem", {16'd0, rem}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);

    // First en honoured on the first edge after release.
    rst_n = 1'b1;
    do_op(16'd54, 16'd3, 1'b0, lat);
    check_result(16'd54, 16'd3, lat);
    check_idle();

    // Back-to-back: second start in the IDLE cycle right after DONE.
    do_op(16'd100, 16'd7, 1'b1, lat);
    check_result(16'd100, 16'd7, lat);
    do_op(16'd3, 16'd5, 1'b1, lat);
    check_result(16'd3, 16'd5, lat);
    check_idle();

    // Divide by zero, then a normal op clears div_zero.
    do_op(16'd5, 16'd0, 1'b1, lat);
    check_result(16'd5, 16'd0, lat);
    check_idle();
    do_op(16'd65535, 16'd1, 1'b1, lat);
    check_result(16'd65535, 16'd1, lat);
    check_idle();

    // Results hold while idle.
    repeat (5) @(negedge clk);
    check("hold_out", {16'd0, out}, 32'd65535);
    check("hold_rem", {16'd0, rem}, 32'd0);

    // Edge-case table.
    for (int i = 0; i < 7; i++) begin
      do_op(edge_a[i], edge_b[i], 1'b1, lat);
      check_result(edge_a[i], edge_b[i], lat);
      check_idle();
    end

    // en held high, operands scrambled during BUSY.
    @(negedge clk);
    a = 16'd1000; b = 16'd10; en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 5) check("busy_held", {31'd0, busy}, 32'd1);
      if (valid) begin
        pulses++;
        check("held_lat", i + 1, 17);
        check("held_quot", {16'd0, out}, 32'd100);
        check("held_rem", {16'd0, rem}, 32'd0);
        en = 1'b0;
      end else if (en) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    en = 1'b0;
    check("held_pulses", pulses, 1);
    $display("held-en 1000 / 10 -> pulses=%0d", pulses);

    // Reset in the middle of 40000/3: everything clears at once, no valid.
    @(negedge clk);
    a = 16'd40000; b = 16'd3; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {16'd0, out}, 32'd0);
    check("mid_rst_rem", {16'd0, rem}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("rst_no_valid", pulses, 0);
    $display("reset mid-division -> stray pulses=%0d", pulses);
    do_op(16'd40000, 16'd3, 1'b1, lat);
    check_result(16'd40000, 16'd3, lat);
    check_idle();

    // Random sweep with a mix of divisor ranges.
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra, rb;
      int sel;
      sel = int'($urandom_range(0, 9));
      ra  = 16'($urandom);
      if (sel == 0)      rb = 16'd0;
      else if (sel <= 3) rb = 16'($urandom_range(1, 15));
      else if (sel == 4) begin rb = 16'($urandom_range(1, 65535)); ra = 16'($urandom_range(0, int'(rb) - 1)); end
      else               rb = 16'($urandom);
      do_op(ra, rb, 1'b1, lat);
      check_result(ra, rb, lat);
      check_idle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
